// File: rtl/lc3_sweep_ctrl_if.sv
// Bus between the sweep sequencer and whoever hosts it: control/result
// signals plus the three circuit inputs and the circuit output.
interface lc3_sweep_ctrl_if;
  // start is a one-cycle request, taken only while the sequencer is idle;
  // abort overrides start. done pulses once per completed sweep and marks
  // tt/pass/mismatch_cnt valid until the next accepted start.
  logic       start;
  logic       abort;
  logic [7:0] exp_tt;
  logic       lc_out;
  logic       lc_a;
  logic       lc_b;
  logic       lc_c;
  logic       busy;
  logic       done;
  logic [7:0] tt;
  logic       pass;
  logic [3:0] mismatch_cnt;
  logic [1:0] dbg_state;

  modport master (
    output start, abort, exp_tt, lc_out,
    input  lc_a, lc_b, lc_c, busy, done, tt, pass, mismatch_cnt, dbg_state
  );

  modport slave (
    input  start, abort, exp_tt, lc_out,
    output lc_a, lc_b, lc_c, busy, done, tt, pass, mismatch_cnt, dbg_state
  );
endinterface

// File: rtl/lc3_sweep_ctrl.sv
// Walks a 3-input logic circuit through all 8 input vectors, captures its
// truth table and compares it against a latched expected table.
module lc3_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic              clk,
  input logic              rst,
  lc3_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_exp;
  logic [7:0]       r_tt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_mm;
  logic [7:0]       w_tt_next;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Table as it will look after this cycle's sample; lets the final
  // compare see the vector-7 capture on the same edge it is taken.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_vec] = bus.lc_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_tt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mm    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state <= S_SETTLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_exp   <= bus.exp_tt;
            r_tt    <= '0;
            r_pass  <= 1'b0;
            r_mm    <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_mm    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_mm    <= '0;
          end else begin
            r_tt  <= w_tt_next;
            r_cnt <= '0;
            if (r_vec == 3'd7) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_tt_next == r_exp);
              r_mm    <= popcnt8(w_tt_next ^ r_exp);
            end else begin
              r_vec   <= r_vec + 3'd1;
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lc_a         = r_vec[0];
  assign bus.lc_b         = r_vec[1];
  assign bus.lc_c         = r_vec[2];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.tt           = r_tt;
  assign bus.pass         = r_pass;
  assign bus.mismatch_cnt = r_mm;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_lc3_sweep_ctrl.sv
// Bench for lc3_sweep_ctrl: table of full sweeps on a SETTLE_CYCLES=4 unit,
// plus hand sequences for abort, reset, busy restart and a SETTLE_CYCLES=1 unit.
module tb_lc3_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_sweep_ctrl_if if0 ();
  lc3_sweep_ctrl_if if1 ();

  lc3_sweep_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  lc3_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Circuit under control: either the real A.B+B.C gate or an arbitrary table.
  logic       golden;
  logic [7:0] circ_tt;
  assign if0.lc_out = golden ? ((if0.lc_a & if0.lc_b) | (if0.lc_b & if0.lc_c))
                             : circ_tt[{if0.lc_c, if0.lc_b, if0.lc_a}];
  assign if1.lc_out = if1.lc_a;

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_tt(input logic g, input logic [7:0] circ);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      logic a, b, c;
      a = (i % 2) == 1;
      b = ((i / 2) % 2) == 1;
      c = (i / 4) == 1;
      t[i] = g ? ((a && b) || (b && c)) : circ[i];
    end
    return t;
  endfunction

  function automatic int model_diff(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    for (int i = 0; i < 8; i++) if (x[i] != y[i]) n++;
    return n;
  endfunction

  typedef struct {
    logic       golden;
    logic [7:0] circ;
    logic [7:0] exp_tt;
    logic [7:0] want_tt;
    logic       want_pass;
    logic [3:0] want_mm;
  } vec_t;

  vec_t tbl[12];

  // ---------------- drivers ----------------
  task automatic start0(input vec_t v);
    @(negedge clk);
    golden     = v.golden;
    circ_tt    = v.circ;
    if0.exp_tt = v.exp_tt;
    if0.start  = 1'b1;
    @(posedge clk);
    #1;
    if0.start  = 1'b0;
  endtask

  // Full sweep on the 4-cycle unit; optional second start pulse at cycle extra_at.
  task automatic run_sweep(input vec_t v, input int extra_at);
    int lat;
    int busy_n;
    int extra_done;
    exp_q.push_back(v.want_tt);
    start0(v);
    lat    = 0;
    busy_n = 0;
    while (!if0.done && lat < 200) begin
      if (if0.busy) busy_n++;
      if (lat < 40) chk("vector_step", {29'd0, if0.lc_c, if0.lc_b, if0.lc_a}, lat / 5);
      if0.start = (lat == extra_at);
      @(posedge clk);
      #1;
      lat++;
    end
    if0.start = 1'b0;
    chk("done_latency", lat, 40);
    chk("busy_cycles", busy_n, 40);
    chk("tt", if0.tt, exp_q.pop_front());
    chk("pass", if0.pass, v.want_pass);
    chk("mismatch_cnt", if0.mismatch_cnt, v.want_mm);
    chk("busy_at_done", if0.busy, 0);
    chk("vec_after_sweep", {if0.lc_c, if0.lc_b, if0.lc_a}, 3'd7);
    extra_done = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (if0.done) extra_done++;
    end
    chk("single_done", extra_done, 0);
    chk("tt_hold", if0.tt, v.want_tt);
    chk("pass_hold", if0.pass, v.want_pass);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   lat;
    int   n_done;

    rst = 1'b1;
    if0.start = 1'b0; if0.abort = 1'b0; if0.exp_tt = '0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.exp_tt = '0;
    golden = 1'b1; circ_tt = '0;

    tbl[0] = '{1'b1, 8'h00, 8'hC8, 8'hC8, 1'b1, 4'd0};
    tbl[1] = '{1'b1, 8'h00, 8'h00, 8'hC8, 1'b0, 4'd3};
    tbl[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 4'd8};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 4'd0};
    for (int i = 4; i < 12; i++) begin
      tbl[i].golden    = 1'b0;
      tbl[i].circ      = 8'($urandom_range(0, 255));
      tbl[i].exp_tt    = ($urandom_range(0, 1) == 1) ? tbl[i].circ : 8'($urandom_range(0, 255));
      tbl[i].want_tt   = model_tt(1'b0, tbl[i].circ);
      tbl[i].want_pass = (tbl[i].want_tt == tbl[i].exp_tt);
      tbl[i].want_mm   = 4'(model_diff(tbl[i].want_tt, tbl[i].exp_tt));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_tt", if0.tt, 0);
    chk("rst_pass", if0.pass, 0);
    chk("rst_mm", if0.mismatch_cnt, 0);
    chk("rst_vec", {if0.lc_c, if0.lc_b, if0.lc_a}, 0);
    chk("rst_busy1", if1.busy, 0);
    rst = 1'b0;

    // Table sweeps; entry 1 also gets a stray start at cycle 10.
    for (int i = 0; i < 12; i++) run_sweep(tbl[i], (i == 1) ? 10 : -1);

    // Abort at cycle 12 while vector 2 settles.
    v = '{1'b0, 8'hFF, 8'hFF, 8'h03, 1'b0, 4'd0};
    start0(v);
    repeat (12) @(posedge clk);
    #1;
    if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.abort = 1'b0;
    chk("abort_busy", if0.busy, 0);
    chk("abort_done", if0.done, 0);
    chk("abort_pass", if0.pass, 0);
    chk("abort_mm", if0.mismatch_cnt, 0);
    chk("abort_tt", if0.tt, v.want_tt);
    chk("abort_vec", {if0.lc_c, if0.lc_b, if0.lc_a}, 3'd2);
    n_done = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (if0.done || if0.busy) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    // start together with abort in idle is refused.
    @(negedge clk);
    if0.exp_tt = 8'h55;
    if0.start  = 1'b1;
    if0.abort  = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if0.abort = 1'b0;
    chk("abort_beats_start", if0.busy, 0);
    chk("abort_start_tt", if0.tt, 8'h03);

    // Reset during the sample cycle of vector 5.
    v = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd0};
    start0(v);
    repeat (29) @(posedge clk);
    #1;
    chk("pre_rst_vec", {if0.lc_c, if0.lc_b, if0.lc_a}, 3'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_tt", if0.tt, 0);
    chk("midrst_vec", {if0.lc_c, if0.lc_b, if0.lc_a}, 0);
    chk("midrst_pass", if0.pass, 0);
    chk("midrst_mm", if0.mismatch_cnt, 0);
    chk("midrst_done", if0.done, 0);
    v = '{1'b1, 8'h00, 8'hC8, model_tt(1'b1, 8'h00), 1'b1, 4'd0};
    run_sweep(v, -1);

    // One-cycle settle unit with lc_out = A: vector steps every 2 cycles.
    @(negedge clk);
    if1.exp_tt = 8'hAA;
    if1.start  = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    lat = 0;
    while (!if1.done && lat < 100) begin
      if (lat < 16) chk("fast_vector_step", {29'd0, if1.lc_c, if1.lc_b, if1.lc_a}, lat / 2);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("fast_latency", lat, 16);
    chk("fast_tt", if1.tt, 8'hAA);
    chk("fast_pass", if1.pass, 1);
    chk("fast_mm", if1.mismatch_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
